// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM state type and wait-counter width for the data-memory responder
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering, load extension and access legality for RV32I loads/stores
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        illegal, misalign;
  // Store codes are a subset of load codes: BU/HU have no store form
  always_comb begin
    b        = 8'(rword_i >> {off_i, 3'b000});
    h        = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    illegal  = we_i ? !(funct3_i inside {F3_B, F3_H, F3_W})
                    : !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misalign = ((funct3_i == F3_H || funct3_i == F3_HU) && off_i[0]) || (funct3_i == F3_W && off_i != 2'b00);
    err_o    = illegal | misalign;
    be_o     = (err_o || !we_i) ? 4'b0000 :
               funct3_i == F3_B ? 4'b0001 << off_i :
               funct3_i == F3_H ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_o  = funct3_i == F3_B ? {4{wdata_i[7:0]}} :
               funct3_i == F3_H ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o  = (err_o || we_i)   ? 32'h0 :
               funct3_i == F3_B  ? {{24{b[7]}}, b} :
               funct3_i == F3_H  ? {{16{h[15]}}, h} :
               funct3_i == F3_BU ? {24'h0, b} :
               funct3_i == F3_HU ? {16'h0, h} : rword_i;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory slave with LATENCY wait states and RV32I byte/half/word access.
// Define DMEM_ACCESS_COUNT_EN to add rd_count/wr_count counters of error-free completed accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);
  localparam int IW = $clog2(DEPTH);
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q, req_ready_q, rsp_valid_q, rsp_err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rsp_rdata_q;
  logic [31:0]       mem [DEPTH];
  logic              a_we, acc, oor, aerr, err_d;
  logic [2:0]        a_f3;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata, wd, rd, rdata_d;
  logic [IW-1:0]     idx;
  logic [3:0]        be;
  // With LATENCY=0 the access happens on the accepting edge, so operands come straight from the request
  always_comb begin
    a_we    = state_q == IDLE ? req_we : we_q;
    a_f3    = state_q == IDLE ? req_funct3 : f3_q;
    a_addr  = state_q == IDLE ? req_addr : addr_q;
    a_wdata = state_q == IDLE ? req_wdata : wdata_q;
    idx     = a_addr[IW+1:2];
    oor     = (a_addr >> (IW + 2)) != '0;
    acc     = reset && (state_q == IDLE ? req_valid && LATENCY == 0 : state_q == WAIT && cnt_q == '0);
    err_d   = aerr | oor;
    rdata_d = err_d ? 32'h0 : rd;
  end
  dmem_lane_align u_align (
    .we_i     (a_we),
    .funct3_i (a_f3),
    .off_i    (a_addr[1:0]),
    .wdata_i  (a_wdata),
    .rword_i  (mem[idx]),
    .be_o     (be),
    .wdata_o  (wd),
    .rdata_o  (rd),
    .err_o    (aerr)
  );
  always_ff @(posedge clk)
    if (acc && !err_d)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rd_q, wr_q;
  assign rd_count = rd_q;
  assign wr_count = wr_q;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef DMEM_ACCESS_COUNT_EN
      rd_q        <= '0;
      wr_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q        <= req_we;
          f3_q        <= req_funct3;
          addr_q      <= req_addr;
          wdata_q     <= req_wdata;
          req_ready_q <= 1'b0;
          if (LATENCY == 0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(LATENCY - 1);
          end
        end
        WAIT: if (cnt_q == '0) begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rdata_d;
          rsp_err_q   <= err_d;
        end else cnt_q <= cnt_q - 1'b1;
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
`ifdef DMEM_ACCESS_COUNT_EN
          if (!rsp_err_q) begin
            if (we_q) wr_q <= wr_q + 1'b1;
            else rd_q <= rd_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder (LATENCY=2) plus a LATENCY=0 back-to-back instance
module tb_dmem_responder;
  localparam int LAT = 2;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic        req_valid = 0, req_we = 0, rsp_ready = 0, req_ready, rsp_valid, rsp_err;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic        z_req_valid = 0, z_req_we = 0, z_rsp_ready = 0, z_req_ready, z_rsp_valid, z_rsp_err;
  logic [2:0]  z_req_funct3 = 0;
  logic [31:0] z_req_addr = 0, z_req_wdata = 0, z_rsp_rdata;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rd_count, wr_count, z_rd_count, z_wr_count;
`endif
  dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_ACCESS_COUNT_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );
  dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_funct3(z_req_funct3), .req_addr(z_req_addr), .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid),
    .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
`ifdef DMEM_ACCESS_COUNT_EN
    , .rd_count(z_rd_count), .wr_count(z_wr_count)
`endif
  );

  typedef struct {logic [31:0] rdata; logic err; logic we; int acc;} exp_t;
  exp_t        sbq[$];
  logic [31:0] mm[int];
  int n_pass = 0, n_chk = 0, cyc = 0, rdy_mode = 0, exp_rd = 0, exp_wr = 0;
  logic prev_v = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: legality and lane rules evaluated on a word-indexed memory image
  function automatic exp_t model(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    logic [31:0] w;
    int idx = int'(a[11:2]);
    int sh = 8 * int'(a[1:0]);
    bit ok = we ? (f3 inside {0, 1, 2}) : (f3 inside {0, 1, 2, 4, 5});
    e.rdata = 0; e.we = we; e.acc = 0;
    e.err = !ok || a >= 32'd4096 || (f3[1:0] == 2'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
    if (!e.err) begin
      w = mm.exists(idx) ? mm[idx] : 32'h0;
      if (we) begin
        case (f3)
          3'd0: w[sh +: 8] = wd[7:0];
          3'd1: w[sh +: 16] = wd[15:0];
          default: w = wd;
        endcase
        mm[idx] = w;
      end else begin
        case (f3)
          3'd0: e.rdata = {{24{w[sh+7]}}, w[sh +: 8]};
          3'd1: e.rdata = {{16{w[sh+15]}}, w[sh +: 16]};
          3'd4: e.rdata = {24'h0, w[sh +: 8]};
          3'd5: e.rdata = {16'h0, w[sh +: 16]};
          default: e.rdata = w;
        endcase
      end
    end
    return e;
  endfunction

  task automatic issue(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int t = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready) begin
      @(negedge clk);
      if (++t > 100) begin
        n_chk++; $display("FAIL issue_timeout: req_ready stuck at 0, required 1");
        req_valid = 0; return;
      end
    end
    e = model(we, f3, a, wd);
    e.acc = cyc;
    sbq.push_back(e);
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || !req_ready) && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin n_chk++; $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size()); end
  endtask

  initial forever begin
    @(posedge clk); #1;
    rsp_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(1)) : 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin exp_rd = 0; exp_wr = 0; end
    if (reset && rsp_valid) begin
      if (!prev_v && sbq.size() > 0) chk("latency", 32'(cyc), 32'(sbq[0].acc + LAT + 1));
      if (rsp_ready) begin
        if (sbq.size() == 0) begin
          n_chk++; $display("FAIL rsp_unexpected: rsp_valid=1 with no outstanding request, required 0");
        end else begin
          e = sbq.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (!e.err) begin if (e.we) exp_wr++; else exp_rd++; end
        end
      end
    end
    prev_v <= reset && rsp_valid;
  end

  localparam logic [2:0]  ZF [5] = '{3'd2, 3'd2, 3'd0, 3'd5, 3'd1};
  localparam logic        ZW [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [31:0] ZA [5] = '{32'h40, 32'h40, 32'h43, 32'h42, 32'h41};
  localparam logic [31:0] ZR [5] = '{32'h0, 32'hCAFEF00D, 32'hFFFFFFCA, 32'h0000CAFE, 32'h0};
  localparam logic        ZE [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int t;
    logic [2:0] f3;
    logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); @(negedge clk); reset = 1;
    // LATENCY=0: accept every other cycle, response one cycle after acceptance
    z_rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      z_req_valid = 1; z_req_we = ZW[i]; z_req_funct3 = ZF[i]; z_req_addr = ZA[i]; z_req_wdata = 32'hCAFEF00D;
      chk("z_req_ready", 32'(z_req_ready), 32'd1);
      @(negedge clk);
      chk("z_rsp_valid", 32'(z_rsp_valid), 32'd1);
      chk("z_req_ready_resp", 32'(z_req_ready), 32'd0);
      chk("z_rsp_rdata", z_rsp_rdata, ZR[i]);
      chk("z_rsp_err", 32'(z_rsp_err), 32'(ZE[i]));
    end
    z_req_valid = 0;
    @(negedge clk);
    chk("z_rsp_valid_idle", 32'(z_rsp_valid), 32'd0);
`ifdef DMEM_ACCESS_COUNT_EN
    chk("z_rd_count", z_rd_count, 32'd3);
    chk("z_wr_count", z_wr_count, 32'd1);
`endif
    for (int w = 0; w < 16; w++) issue(1, 3'd2, 32'(w * 4), $urandom);
    issue(1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(0, 3'd2, 32'h10, 0);
    issue(1, 3'd0, 32'h13, 32'h80);
    issue(0, 3'd0, 32'h13, 0);
    issue(0, 3'd4, 32'h13, 0);
    issue(0, 3'd2, 32'h10, 0);
    issue(0, 3'd1, 32'h11, 0);
    issue(0, 3'd2, 32'h12, 0);
    issue(1, 3'd2, 32'h1000, 32'h11111111);
    issue(0, 3'd2, 32'h0, 0);
    drain();
    // Stalled response must hold and block new requests
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    issue(0, 3'd2, 32'h10, 0);
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    chk("stall_rsp_valid_rise", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = i[0]; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h55555555;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      if (sbq.size() > 0) begin
        chk("stall_rsp_rdata", rsp_rdata, sbq[0].rdata);
        chk("stall_rsp_err", 32'(rsp_err), 32'(sbq[0].err));
      end
    end
    req_valid = 0;
    rdy_mode = 0;
    drain();
    issue(0, 3'd2, 32'h10, 0);
    drain();
    // Reset during WAIT abandons the store
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    reset = 0;
    #1;
    chk("wait_reset_req_ready", 32'(req_ready), 32'd1);
    chk("wait_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wait_reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("wait_reset_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); @(negedge clk); reset = 1;
    issue(0, 3'd2, 32'h20, 0);
    drain();
    rdy_mode = 1;
    for (int i = 0; i < 80; i++) begin
      f3 = $urandom_range(0, 9) < 8 ? f3s[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 2) == 0), f3,
            $urandom_range(0, 15) == 0 ? 32'h1000 + $urandom_range(0, 255) : 32'($urandom_range(0, 63)),
            $urandom);
    end
    drain();
    rdy_mode = 0;
    @(negedge clk);
`ifdef DMEM_ACCESS_COUNT_EN
    chk("rd_count", rd_count, 32'(exp_rd));
    chk("wr_count", wr_count, 32'(exp_wr));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the load/store requests issued by the single-cycle RISC-V core's datapath. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. It performs byte/half/word access with sign/zero extension per RV32I funct3, then returns a held response. It is the memory-side end of the core's MemRead/MemWrite/Funct3/ALU-address interface.

Parameters:
ADDR_W, 32, byte-address width of req_addr
DEPTH, 1024, number of 32-bit words in the internal array; a power of two
LATENCY, 2, wait-state cycles between request acceptance and the array access (0..15)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_W  byte address (ALU result)
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  32  load data, extended; 0 for stores and errors
rsp_err  out  1  misaligned access, out-of-range access, or illegal funct3

Behaviour:
- Reset (asynchronous, active-low) values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM in IDLE, wait counter 0. Array contents are not reset.
- The FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid is 1, register we, funct3, addr and wdata.
  - If LATENCY=0, go to RESP; otherwise load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle; when it reaches 0, go to RESP.
  - The array access happens on the transition into RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_ready=1.
  - On rsp_ready, return to IDLE with rsp_valid=0.
  - req_ready=0 in RESP, so no request can be accepted in the same cycle as a response handshake.
- Latency: rsp_valid rises LATENCY+1 cycles after the accepting edge.
- Loads:
  - funct3 000=LB and 001=LH are sign-extended.
  - funct3 010=LW returns the full word.
  - funct3 100=LBU and 101=LHU are zero-extended.
  - Lane selection uses addr[1:0].
- Stores:
  - funct3 000=SB writes byte lane addr[1:0] from wdata[7:0].
  - funct3 001=SH writes half lane addr[1] from wdata[15:0].
  - funct3 010=SW writes all four lanes.
  - Unselected bytes are unchanged.
- Word index is addr[log2(DEPTH)+1:2].
- Errors:
  - Causes: a halfword at an odd address; a word with addr[1:0]!=0; addr >= 4*DEPTH; any funct3 other than those listed above.
  - Result: rsp_err=1, rsp_rdata=0, no array write, and the response is still delivered.
- Reset asserted in WAIT abandons the request with no write; reset asserted in RESP drops the response.

Optional Feature:
DMEM_ACCESS_COUNT_EN:
- Defined: adds outputs rd_count[31:0] and wr_count[31:0], both reset to 0.
  - A counter increments once per completed response handshake without error: rd_count for loads, wr_count for stores.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state typedef enum {IDLE, WAIT, RESP};
  - the LATENCY counter width constant (4).
- Sub-module dmem_lane_align is purely combinational. It takes funct3, addr[1:0], wdata and the read word, and produces:
  - 4-bit byte enable;
  - shifted write data;
  - extended load data;
  - misalign/illegal flag.
- The FSM, counter and array stay in dmem_responder.

Test Plan:
- SW addr=0x10 data=0xDEADBEEF, then LW 0x10 with LATENCY=2 -> rsp_valid rises 3 cycles after acceptance; rdata=0xDEADBEEF, err=0.
- SB 0x13 data=0x80, then LB 0x13 -> rdata=0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
- LH 0x11 -> err=1, rdata=0; LW 0x12 -> err=1; SW 0x1000 with DEPTH=1024 -> err=1; a following LW 0x0 returns the prior contents unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready=0; req_valid pulses during this time are ignored.
- Assert reset during WAIT of SW 0x20=0x12345678 -> outputs take reset values; a following LW 0x20 returns the previous word, unchanged.
- LATENCY=0 back-to-back: LW accepted at cycle n -> rsp_valid at n+1; with rsp_ready=1 the next request is accepted at n+2. With DMEM_ACCESS_COUNT_EN, after 3 good loads and 1 erroneous load, rd_count=3.
